// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch way scheduler:
//               FSM state encoding, way-select encoding, default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Scheduler FSM states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  // Which fetch way receives the next delivered instruction
  typedef enum logic {
    WAY0 = 1'b0,
    WAY1 = 1'b1
  } way_sel_e;

  // First fetch address after reset unless overridden at instantiation
  localparam logic [31:0] c_default_reset_pc = 32'h8000_0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_way_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_way_scheduler
// Description : Issues single-outstanding instruction-memory reads and
//               distributes the returned instructions alternately to two
//               fetch ways (way0, way1, way0, ...). Redirects restart the
//               stream at way0; a read already in flight at redirect time
//               is drained and discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_way_scheduler #(
  parameter logic [31:0] RESET_PC = fetch_pkg::c_default_reset_pc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        way0_ready_i,
  input  logic        way1_ready_i,
  output logic        way0_valid_o,
  output logic        way1_valid_o,
  output logic [31:0] way_inst_o,
  output logic [31:0] way_addr_o,
  output logic        jump_flag_o
);

  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  way_sel_e     tgt_q, tgt_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  addr_q, addr_d;
  logic         way0_valid_q, way0_valid_d;
  logic         way1_valid_q, way1_valid_d;
  logic         w_tgt_ready;
  logic         w_req;

  // Request only when the way that will receive the data has room; a redirect
  // in the same cycle withdraws the request since the address is now stale.
  assign w_tgt_ready = (tgt_q == WAY0) ? way0_ready_i : way1_ready_i;
  assign w_req       = (state_q == ST_REQ) && w_tgt_ready && !jump_i;

  // Next-state, pc, way-select and delivery-register computation
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    addr_d       = addr_q;
    way0_valid_d = 1'b0;
    way1_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        // A grant racing a redirect still leaves a read in flight to drain
        if (jump_i && imem_gnt_i) begin
          state_d = ST_DROP;
        end else if (w_req && imem_gnt_i) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
          if (!jump_i) begin
            inst_d       = imem_rdata_i;
            addr_d       = pc_q;
            way0_valid_d = (tgt_q == WAY0);
            way1_valid_d = (tgt_q == WAY1);
            pc_d         = pc_q + 32'd4;
            tgt_d        = (tgt_q == WAY0) ? WAY1 : WAY0;
          end
        end else if (jump_i) begin
          state_d = ST_DROP;
        end
      end

      // The in-flight read is consumed here even if another redirect arrives
      // with it; otherwise the FSM would wait for a response that never comes.
      ST_DROP: begin
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A redirect always wins over sequential pc advance
    if (jump_i) begin
      pc_d  = jump_addr_i;
      tgt_d = WAY0;
    end
  end

  // State, pc and delivery registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tgt_q        <= WAY0;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      addr_q       <= 32'd0;
      way0_valid_q <= 1'b0;
      way1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      addr_q       <= addr_d;
      way0_valid_q <= way0_valid_d;
      way1_valid_q <= way1_valid_d;
    end
  end

  // Outputs are forced quiet for the whole reset cycle, not only after the
  // first reset edge; strobes never coincide with a flush.
  assign imem_req_o   = w_req && !reset;
  assign imem_addr_o  = pc_q;
  assign way0_valid_o = way0_valid_q && !jump_i && !reset;
  assign way1_valid_o = way1_valid_q && !jump_i && !reset;
  assign way_inst_o   = reset ? 32'd0 : inst_q;
  assign way_addr_o   = reset ? 32'd0 : addr_q;
  assign jump_flag_o  = jump_i;

endmodule : fetch_way_scheduler
`default_nettype wire

// File: tb/tb_fetch_way_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_way_scheduler
// Description : Directed scoreboard bench for fetch_way_scheduler. Stimulus
//               pushes expected deliveries; a monitor pops and compares
//               whenever a way strobe is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_way_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        way0_ready_i = 1'b1;
  logic        way1_ready_i = 1'b1;
  logic        way0_valid_o;
  logic        way1_valid_o;
  logic [31:0] way_inst_o;
  logic [31:0] way_addr_o;
  logic        jump_flag_o;

  typedef struct packed {
    logic        way;
    logic [31:0] inst;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_way_scheduler #(.RESET_PC(32'h8000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .way0_ready_i (way0_ready_i),
    .way1_ready_i (way1_ready_i),
    .way0_valid_o (way0_valid_o),
    .way1_valid_o (way1_valid_o),
    .way_inst_o   (way_inst_o),
    .way_addr_o   (way_addr_o),
    .jump_flag_o  (jump_flag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Monitor: inputs change at the falling edge, outputs are read 1ns later
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (way0_valid_o || way1_valid_o) begin
        if (way0_valid_o && way1_valid_o) begin
          n_cmp++; n_bad++;
          $display("FAIL both_strobes: got 11 expected one-hot");
        end else if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_strobe: got addr %h inst %h expected none", way_addr_o, way_inst_o);
        end else begin
          e = sb.pop_front();
          check1("deliver_way", way1_valid_o, e.way);
          check("deliver_inst", way_inst_o, e.inst);
          check("deliver_addr", way_addr_o, e.addr);
        end
      end
    end
  end

  // Called at a falling edge; returns at +2ns of the cycle where req is seen
  task automatic wait_req(input logic [31:0] exp_addr, input string name);
    int n = 0;
    #2;
    while (!imem_req_o && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    check1({name, "_req"}, imem_req_o, 1'b1);
    check({name, "_addr"}, imem_addr_o, exp_addr);
  endtask

  // One complete fetch: optional grant stall, optional wait before rvalid
  task automatic fetch(input logic [31:0] data, input logic [31:0] exp_addr, input logic exp_way,
                       input int gnt_dly, input int gap, input string name);
    wait_req(exp_addr, name);
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      #2;
      check1({name, "_stall_req"}, imem_req_o, 1'b1);
      check({name, "_stall_addr"}, imem_addr_o, exp_addr);
    end
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0;
    repeat (gap) @(negedge clk);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    sb.push_back({exp_way, data, exp_addr});
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    #2;
    check1("rst_req", imem_req_o, 1'b0);
    check1("rst_v0", way0_valid_o, 1'b0);
    check1("rst_v1", way1_valid_o, 1'b0);
    check("rst_inst", way_inst_o, 32'd0);
    check("rst_addr", way_addr_o, 32'd0);

    // One IDLE cycle, then requesting from RESET_PC
    @(negedge clk);
    reset = 1'b0;
    #2;
    check1("idle_req", imem_req_o, 1'b0);
    @(negedge clk);
    #2;
    check1("idle_one_cycle", imem_req_o, 1'b1);
    check("first_addr", imem_addr_o, 32'h8000_0000);

    // Sequential stream; way1 backpressure holds the request off
    fetch(32'hA000_0001, 32'h8000_0000, 1'b0, 0, 0, "a");
    way1_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check1("bp_req", imem_req_o, 1'b0);
      check("bp_addr", imem_addr_o, 32'h8000_0004);
      @(negedge clk);
    end
    way1_ready_i = 1'b1;
    fetch(32'hA000_0002, 32'h8000_0004, 1'b1, 1, 0, "b");
    fetch(32'hA000_0003, 32'h8000_0008, 1'b0, 0, 2, "c");

    // Redirect in WAIT without rvalid: drain the late response
    wait_req(32'h8000_000C, "d_pre");
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i  = 1'b0;
    jump_i      = 1'b1;
    jump_addr_i = 32'h0000_1000;
    #2;
    check1("jump_flag", jump_flag_o, 1'b1);
    @(negedge clk);
    jump_i = 1'b0;
    #2;
    check1("drop_req", imem_req_o, 1'b0);
    @(negedge clk);
    #2;
    check1("drop_hold", imem_req_o, 1'b0);
    @(negedge clk);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_0001;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    fetch(32'hD000_0001, 32'h0000_1000, 1'b0, 0, 0, "d");
    fetch(32'hD000_0002, 32'h0000_1004, 1'b1, 0, 1, "e");

    // Redirect coincident with rvalid: data discarded
    wait_req(32'h0000_1008, "f_pre");
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_0002;
    jump_i        = 1'b1;
    jump_addr_i   = 32'h0000_2000;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    jump_i        = 1'b0;
    #2;
    check1("jr_v0", way0_valid_o, 1'b0);
    check1("jr_v1", way1_valid_o, 1'b0);
    fetch(32'hF000_0001, 32'h0000_2000, 1'b0, 0, 0, "f");

    // Strobe suppressed by a redirect in the delivery cycle
    wait_req(32'h0000_2004, "g_pre");
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h6000_0001;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    jump_i        = 1'b1;
    jump_addr_i   = 32'hFFFF_FFFC;
    #2;
    check1("gate_v1", way1_valid_o, 1'b0);
    check1("gate_flag", jump_flag_o, 1'b1);
    check1("gate_req", imem_req_o, 1'b0);
    @(negedge clk);
    jump_i = 1'b0;

    // pc wraps modulo 2^32
    fetch(32'h1000_0001, 32'hFFFF_FFFC, 1'b0, 0, 0, "h");
    fetch(32'h1000_0002, 32'h0000_0000, 1'b1, 0, 0, "i");

    // Redirect with a same-cycle grant: drain via DROP
    wait_req(32'h0000_0004, "j_pre");
    imem_gnt_i  = 1'b1;
    jump_i      = 1'b1;
    jump_addr_i = 32'h0000_3000;
    @(negedge clk);
    imem_gnt_i = 1'b0;
    jump_i     = 1'b0;
    #2;
    check1("jg_drop_req", imem_req_o, 1'b0);
    @(negedge clk);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_0003;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    fetch(32'h3000_0001, 32'h0000_3000, 1'b0, 0, 0, "j");

    // Reset while WAIT, stray rvalid during IDLE
    wait_req(32'h0000_3004, "k_pre");
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0;
    reset      = 1'b1;
    #2;
    check1("mrst_req", imem_req_o, 1'b0);
    check("mrst_inst", way_inst_o, 32'd0);
    check("mrst_addr", way_addr_o, 32'd0);
    @(negedge clk);
    reset         = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_0004;
    #2;
    check1("mrst_idle_req", imem_req_o, 1'b0);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    fetch(32'h8000_AAAA, 32'h8000_0000, 1'b0, 0, 0, "k");

    repeat (3) @(negedge clk);
    #2;
    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_way_scheduler
`default_nettype wire

// File: doc/fetch_way_scheduler.md
FETCH_WAY_SCHEDULER -- requirements
Module: fetch_way_scheduler

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 jump_i  in  1  redirect request, single-cycle pulse.
REQ-005 jump_addr_i  in  32  redirect target, word-aligned.
REQ-006 imem_req_o  out  1  instruction-memory request.
REQ-007 imem_addr_o  out  32  request address.
REQ-008 imem_gnt_i  in  1  request accepted this cycle.
REQ-009 imem_rvalid_i  in  1  read data valid; at most one outstanding.
REQ-010 imem_rdata_i  in  32  fetched instruction.
REQ-011 way0_ready_i / way1_ready_i  in  1 each  fetch way can accept one entry.
REQ-012 way0_valid_o / way1_valid_o  out  1 each  one-cycle write strobe into that way.
REQ-013 way_inst_o  out  32  instruction, shared by both ways.
REQ-014 way_addr_o  out  32  instruction address, shared by both ways.
REQ-015 jump_flag_o  out  1  flush to both ways; equals jump_i combinationally.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT and DROP.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then enter REQ.
REQ-018 In REQ, imem_req_o SHALL be high only while the target way's ready_i is high; imem_addr_o = pc.
REQ-019 imem_req_o and imem_addr_o SHALL remain stable until imem_gnt_i, except on jump.
REQ-020 REQ with req high and imem_gnt_i high, no jump -> WAIT.
REQ-021 WAIT with imem_rvalid_i, no jump -> REQ next cycle; pc <= pc+4; target way toggles.
REQ-022 Delivery timing: one cycle after a rvalid accepted in WAIT, the target way's valid_o SHALL be high for exactly one cycle.
REQ-023 way_inst_o / way_addr_o SHALL be registered copies of imem_rdata_i and the request pc.
REQ-024 The target way SHALL start at way0 and alternate way0, way1, way0...; even program-order slots go to way0.
REQ-025 Jump in REQ without grant: pc <= jump_addr_i; target <= way0; stay REQ; req deasserts that cycle.
REQ-026 Jump in REQ with a same-cycle grant: pc <= jump_addr_i; target <= way0; -> DROP.
REQ-027 Jump in WAIT with a same-cycle rvalid: discard the data (no valid_o next cycle); pc <= jump_addr_i; target <= way0; -> REQ.
REQ-028 Jump in WAIT without rvalid: pc <= jump_addr_i; target <= way0; -> DROP.
REQ-029 DROP SHALL issue no request, discard the next rvalid, then enter REQ.
REQ-030 Jump in DROP SHALL update pc and reset target to way0 while remaining in DROP.
REQ-031 wayN_valid_o SHALL be gated by ~jump_i, so no strobe coincides with jump_flag_o.
REQ-032 pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
REQ-033 A way's ready dropping after grant SHALL NOT stall delivery; the ways guarantee space when ready at issue.

Reset
REQ-034 While reset is high: state=IDLE, pc=RESET_PC, target=way0.
REQ-035 While reset is high: imem_req_o, wayN_valid_o, way_inst_o and way_addr_o = 0.
REQ-036 Reset asserted during WAIT/DROP SHALL abandon the outstanding request; the first rvalid after reset SHALL be ignored while not in WAIT.

Structure
REQ-037 Package fetch_pkg SHALL hold the FSM state enum, the way-select enum and the default RESET_PC constant.
REQ-038 No sub-module: FSM, pc register and output registers are implemented inline.

Verification
REQ-039 Reset release, ways always ready, gnt and rvalid one cycle apart -> way0 gets 8000_0000, way1 8000_0004, way0 8000_0008.
REQ-040 way1_ready_i held low after the first delivery -> imem_req_o stays low in REQ until ready rises; the address remains 8000_0004.
REQ-041 Jump to 0000_1000 in WAIT without rvalid -> DROP; late rvalid discarded; next request 0000_1000 delivered to way0.
REQ-042 Jump coincident with rvalid -> no valid_o next cycle; next request is jump_addr_i.
REQ-043 pc = FFFF_FFFC fetched -> next request address 0000_0000.
REQ-044 Reset pulsed in WAIT, stray rvalid in IDLE -> no valid_o; fetch restarts at RESET_PC to way0.
